// File: rtl/regfile_bypass_2w_pkg.sv
// Shared defaults for the two-write-port bypassed register file.
package regfile_bypass_2w_pkg;

    localparam int DATA_W_DEF   = 16;
    localparam int NUM_REGS_DEF = 8;
    localparam int SEL_W_DEF    = 3;

endpackage

// File: rtl/regfile_store.sv
// Plain register storage: two asynchronous read ports, two write ports, no bypass.
// When both writes hit the same register, port 0 (the younger writeback) is kept.
module regfile_store
    import regfile_bypass_2w_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int SEL_W    = SEL_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  rd0_sel,
    output logic [DATA_W-1:0] rd0_data,
    input  logic [SEL_W-1:0]  rd1_sel,
    output logic [DATA_W-1:0] rd1_data,
    input  logic              wr0_en,
    input  logic [SEL_W-1:0]  wr0_sel,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_en,
    input  logic [SEL_W-1:0]  wr1_sel,
    input  logic [DATA_W-1:0] wr1_data
);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] mem_d;

    // NOTE: mem_d gets a full default before the conditional updates, so no latch is
    // inferred; ordering port 0 last makes it win an address collision.
    always_comb begin
        mem_d = mem_q;
        if (wr1_en) mem_d[wr1_sel] = wr1_data;
        if (wr0_en) mem_d[wr0_sel] = wr0_data;
    end

    // NOTE: the array is reset as ordinary flops because every register must read zero
    // after reset; state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) mem_q <= '0;
        else     mem_q <= mem_d;
    end

    assign rd0_data = mem_q[rd0_sel];
    assign rd1_data = mem_q[rd1_sel];

endmodule

// File: rtl/regfile_bypass_2w.sv
// Register file with zero-cycle write bypass, a per-register reservation scoreboard
// and a combinational write-conflict flag. Storage lives in regfile_store.
module regfile_bypass_2w
    import regfile_bypass_2w_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int SEL_W    = SEL_W_DEF,
    parameter bit ZERO_R0  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  read1RegSel,
    input  logic [SEL_W-1:0]  read2RegSel,
    output logic [DATA_W-1:0] read1Data,
    output logic [DATA_W-1:0] read2Data,
    output logic              read1Busy,
    output logic              read2Busy,
    input  logic              wr0En,
    input  logic [SEL_W-1:0]  wr0RegSel,
    input  logic [DATA_W-1:0] wr0Data,
    input  logic              wr1En,
    input  logic [SEL_W-1:0]  wr1RegSel,
    input  logic [DATA_W-1:0] wr1Data,
    input  logic              resvEn,
    input  logic [SEL_W-1:0]  resvRegSel,
    output logic              err
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                wr0_en_eff;
    logic                wr1_en_eff;
    logic                resv_en_eff;
    logic [DATA_W-1:0]   store1_data;
    logic [DATA_W-1:0]   store2_data;

    // With ZERO_R0 set, register 0 is a constant: no write or reservation reaches it.
    always_comb begin
        wr0_en_eff  = wr0En  && !(ZERO_R0 && wr0RegSel  == '0);
        wr1_en_eff  = wr1En  && !(ZERO_R0 && wr1RegSel  == '0);
        resv_en_eff = resvEn && !(ZERO_R0 && resvRegSel == '0);
    end

    regfile_store #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_store (
        .clk      (clk),
        .rst      (rst),
        .rd0_sel  (read1RegSel),
        .rd0_data (store1_data),
        .rd1_sel  (read2RegSel),
        .rd1_data (store2_data),
        .wr0_en   (wr0_en_eff),
        .wr0_sel  (wr0RegSel),
        .wr0_data (wr0Data),
        .wr1_en   (wr1_en_eff),
        .wr1_sel  (wr1RegSel),
        .wr1_data (wr1Data)
    );

    // Writebacks clear first, then a reservation sets, so an issue in the same cycle as
    // the old producer's writeback leaves the register owned by the new producer.
    always_comb begin
        busy_d = busy_q;
        if (wr1_en_eff)  busy_d[wr1RegSel]  = 1'b0;
        if (wr0_en_eff)  busy_d[wr0RegSel]  = 1'b0;
        if (resv_en_eff) busy_d[resvRegSel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    // Bypass mux, lowest priority assigned first.
    always_comb begin
        read1Data = store1_data;
        if (wr1En && wr1RegSel == read1RegSel) read1Data = wr1Data;
        if (wr0En && wr0RegSel == read1RegSel) read1Data = wr0Data;
        if (ZERO_R0 && read1RegSel == '0)      read1Data = '0;

        read2Data = store2_data;
        if (wr1En && wr1RegSel == read2RegSel) read2Data = wr1Data;
        if (wr0En && wr0RegSel == read2RegSel) read2Data = wr0Data;
        if (ZERO_R0 && read2RegSel == '0)      read2Data = '0;
    end

    // A value arriving this cycle is already bypassed, so the reader need not wait.
    always_comb begin
        read1Busy = busy_q[read1RegSel]
                  && !(wr0En && wr0RegSel == read1RegSel)
                  && !(wr1En && wr1RegSel == read1RegSel)
                  && !(ZERO_R0 && read1RegSel == '0);
        read2Busy = busy_q[read2RegSel]
                  && !(wr0En && wr0RegSel == read2RegSel)
                  && !(wr1En && wr1RegSel == read2RegSel)
                  && !(ZERO_R0 && read2RegSel == '0);
    end

    // Unknown controls only matter in simulation; synthesis treats $isunknown as false.
    always_comb begin
        err = wr0En && wr1En && (wr0RegSel == wr1RegSel)
            && !(ZERO_R0 && wr0RegSel == '0);
        if ($isunknown({wr0En, wr1En, resvEn, read1RegSel, read2RegSel})
            || (wr0En  && $isunknown(wr0RegSel))
            || (wr1En  && $isunknown(wr1RegSel))
            || (resvEn && $isunknown(resvRegSel)))
            err = 1'b1;
    end

endmodule

// File: tb/tb_regfile_bypass_2w.sv
// Scenario bench for regfile_bypass_2w: one instance with ZERO_R0=0, one with ZERO_R0=1,
// both driven by the same stimulus; expectations go through a scoreboard queue.
module tb_regfile_bypass_2w;

    typedef struct {
        logic        rst;
        logic        w0;
        logic [2:0]  w0s;
        logic [15:0] w0d;
        logic        w1;
        logic [2:0]  w1s;
        logic [15:0] w1d;
        logic        rv;
        logic [2:0]  rvs;
        logic [2:0]  r1;
        logic [2:0]  r2;
    } stim_t;

    typedef struct packed {
        logic [15:0] d1;
        logic [15:0] d2;
        logic        b1;
        logic        b2;
        logic        e;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  read1RegSel, read2RegSel, wr0RegSel, wr1RegSel, resvRegSel;
    logic [15:0] wr0Data, wr1Data;
    logic        wr0En, wr1En, resvEn;
    logic [15:0] read1Data, read2Data, z_read1Data, z_read2Data;
    logic        read1Busy, read2Busy, err, z_read1Busy, z_read2Busy, z_err;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    regfile_bypass_2w #(.DATA_W(16), .NUM_REGS(8), .SEL_W(3), .ZERO_R0(1'b0)) dut (
        .clk(clk), .rst(rst),
        .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .read1Data(read1Data), .read2Data(read2Data),
        .read1Busy(read1Busy), .read2Busy(read2Busy),
        .wr0En(wr0En), .wr0RegSel(wr0RegSel), .wr0Data(wr0Data),
        .wr1En(wr1En), .wr1RegSel(wr1RegSel), .wr1Data(wr1Data),
        .resvEn(resvEn), .resvRegSel(resvRegSel), .err(err)
    );

    regfile_bypass_2w #(.DATA_W(16), .NUM_REGS(8), .SEL_W(3), .ZERO_R0(1'b1)) dut_z (
        .clk(clk), .rst(rst),
        .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .read1Data(z_read1Data), .read2Data(z_read2Data),
        .read1Busy(z_read1Busy), .read2Busy(z_read2Busy),
        .wr0En(wr0En), .wr0RegSel(wr0RegSel), .wr0Data(wr0Data),
        .wr1En(wr1En), .wr1RegSel(wr1RegSel), .wr1Data(wr1Data),
        .resvEn(resvEn), .resvRegSel(resvRegSel), .err(z_err)
    );

    function automatic stim_t row(input logic rst_i,
                                  input logic w0, input logic [2:0] w0s, input logic [15:0] w0d,
                                  input logic w1, input logic [2:0] w1s, input logic [15:0] w1d,
                                  input logic rv, input logic [2:0] rvs,
                                  input logic [2:0] r1, input logic [2:0] r2);
        stim_t s;
        s.rst = rst_i; s.w0 = w0; s.w0s = w0s; s.w0d = w0d;
        s.w1 = w1; s.w1s = w1s; s.w1d = w1d; s.rv = rv; s.rvs = rvs;
        s.r1 = r1; s.r2 = r2;
        return s;
    endfunction

    function automatic obs_t ex(input logic [15:0] d1, input logic [15:0] d2,
                                input logic b1, input logic b2, input logic e);
        obs_t o;
        o.d1 = d1; o.d2 = d2; o.b1 = b1; o.b2 = b2; o.e = e;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("d1=%h d2=%h b1=%b b2=%b err=%b", o.d1, o.d2, o.b1, o.b2, o.e);
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst;
        wr0En = s.w0; wr0RegSel = s.w0s; wr0Data = s.w0d;
        wr1En = s.w1; wr1RegSel = s.w1s; wr1Data = s.w1d;
        resvEn = s.rv; resvRegSel = s.rvs;
        read1RegSel = s.r1; read2RegSel = s.r2;
    endtask

    // Reset-cycle write is bypassed but discarded; afterwards everything reads zero.
    task automatic test_reset();
        stim_t s;
        obs_t  o, e;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) begin
                s = row(1, 1, 3'd1, 16'hAAAA, 0, 0, 0, 1, 3'd1, 3'd1, 3'd2);
                exp_q.push_back(ex(16'hAAAA, 16'h0000, 0, 0, 0));
            end else begin
                s = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'(i - 1), 3'(8 - i));
                exp_q.push_back(ex(16'h0000, 16'h0000, 0, 0, 0));
            end
            apply(s);
            @(negedge clk);
            o = '{read1Data, read2Data, read1Busy, read2Busy, err};
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_conflict();
        stim_t s[3];
        obs_t  x[3];
        obs_t  o, e;
        s[0] = row(0, 1, 3'd3, 16'h1111, 1, 3'd3, 16'h2222, 0, 0, 3'd3, 3'd3);
        x[0] = ex(16'h1111, 16'h1111, 0, 0, 1);
        s[1] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd3, 3'd1);
        x[1] = ex(16'h1111, 16'h0000, 0, 0, 0);
        s[2] = row(0, 1, 3'd0, 16'h00A0, 1, 3'd0, 16'h00B0, 0, 0, 3'd0, 3'd3);
        x[2] = ex(16'h00A0, 16'h1111, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            apply(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            o = '{read1Data, read2Data, read1Busy, read2Busy, err};
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL conflict[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bypass();
        stim_t s[4];
        obs_t  x[4];
        obs_t  o, e;
        s[0] = row(0, 0, 0, 0, 1, 3'd5, 16'hBEEF, 0, 0, 3'd0, 3'd5);
        x[0] = ex(16'h00A0, 16'hBEEF, 0, 0, 0);
        s[1] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd5);
        x[1] = ex(16'h00A0, 16'hBEEF, 0, 0, 0);
        s[2] = row(0, 1, 3'd6, 16'h1234, 1, 3'd7, 16'h5678, 0, 0, 3'd6, 3'd7);
        x[2] = ex(16'h1234, 16'h5678, 0, 0, 0);
        s[3] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd6, 3'd7);
        x[3] = ex(16'h1234, 16'h5678, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            apply(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            o = '{read1Data, read2Data, read1Busy, read2Busy, err};
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL bypass[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_busy();
        stim_t s[5];
        obs_t  x[5];
        obs_t  o, e;
        s[0] = row(0, 0, 0, 0, 0, 0, 0, 1, 3'd2, 3'd2, 3'd3);
        x[0] = ex(16'h0000, 16'h1111, 0, 0, 0);
        s[1] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2, 3'd3);
        x[1] = ex(16'h0000, 16'h1111, 1, 0, 0);
        s[2] = row(0, 0, 0, 0, 0, 0, 0, 1, 3'd2, 3'd2, 3'd3);
        x[2] = ex(16'h0000, 16'h1111, 1, 0, 0);
        s[3] = row(0, 0, 0, 0, 1, 3'd2, 16'h0C0C, 0, 0, 3'd2, 3'd3);
        x[3] = ex(16'h0C0C, 16'h1111, 0, 0, 0);
        s[4] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2, 3'd3);
        x[4] = ex(16'h0C0C, 16'h1111, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            apply(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            o = '{read1Data, read2Data, read1Busy, read2Busy, err};
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL busy[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_resv_write();
        stim_t s[4];
        obs_t  x[4];
        obs_t  o, e;
        s[0] = row(0, 1, 3'd4, 16'h4444, 0, 0, 0, 1, 3'd4, 3'd2, 3'd4);
        x[0] = ex(16'h0C0C, 16'h4444, 0, 0, 0);
        s[1] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2, 3'd4);
        x[1] = ex(16'h0C0C, 16'h4444, 0, 1, 0);
        s[2] = row(0, 0, 0, 0, 1, 3'd4, 16'h4545, 0, 0, 3'd2, 3'd4);
        x[2] = ex(16'h0C0C, 16'h4545, 0, 0, 0);
        s[3] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2, 3'd4);
        x[3] = ex(16'h0C0C, 16'h4545, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            apply(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            o = '{read1Data, read2Data, read1Busy, read2Busy, err};
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL resv_write[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    // Observed on the ZERO_R0=1 instance: r0 is inert, and reset drops reservations.
    task automatic test_zero_r0();
        stim_t s[7];
        obs_t  x[7];
        obs_t  o, e;
        s[0] = row(0, 1, 3'd0, 16'hFFFF, 0, 0, 0, 1, 3'd0, 3'd0, 3'd0);
        x[0] = ex(16'h0000, 16'h0000, 0, 0, 0);
        s[1] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0);
        x[1] = ex(16'h0000, 16'h0000, 0, 0, 0);
        s[2] = row(0, 1, 3'd0, 16'h0001, 1, 3'd0, 16'h0002, 0, 0, 3'd0, 3'd5);
        x[2] = ex(16'h0000, 16'hBEEF, 0, 0, 0);
        s[3] = row(0, 0, 0, 0, 0, 0, 0, 1, 3'd6, 3'd6, 3'd6);
        x[3] = ex(16'h1234, 16'h1234, 0, 0, 0);
        s[4] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd6, 3'd6);
        x[4] = ex(16'h1234, 16'h1234, 1, 1, 0);
        s[5] = row(1, 0, 0, 0, 0, 0, 0, 0, 0, 3'd6, 3'd6);
        x[5] = ex(16'h1234, 16'h1234, 1, 1, 0);
        s[6] = row(0, 0, 0, 0, 0, 0, 0, 0, 0, 3'd6, 3'd6);
        x[6] = ex(16'h0000, 16'h0000, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            apply(s[i]);
            exp_q.push_back(x[i]);
            @(negedge clk);
            o = '{z_read1Data, z_read2Data, z_read1Busy, z_read2Busy, z_err};
            e = exp_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL zero_r0[%0d]: got %s want %s", i, fmt(o), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        apply(row(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_conflict();
        test_bypass();
        test_busy();
        test_resv_write();
        test_zero_r0();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
